// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine integration scheduler: FSM encoding,
// baseline-slot count and counter-width helper.
package xeng_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Baseline-order slots per channel, including autocorrelations.
    function automatic int n_bls(input int n_ants);
        return n_ants * (n_ants / 2 + 1);
    endfunction

    // Counter width for a modulo-range_n counter; never narrower than 1 bit.
    function automatic int log2w(input int range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/xeng_acc_sched_if.sv
// Scheduler-side bundle: input beats/control, accumulator flags and the
// readout req/done handshake.
interface xeng_acc_sched_if #(
    parameter int ACC_LEN_W = 16
);
    logic                 sync_in;
    logic                 din_vld;
    logic [ACC_LEN_W-1:0] acc_len;
    logic                 rd_done;
    logic                 ovf_clr;
    logic                 bl_sync;
    logic                 bl_en;
    logic                 acc_first;
    logic                 acc_last;
    logic                 acc_bank;
    logic                 rd_req;
    logic                 rd_bank;
    logic [ACC_LEN_W-1:0] int_cnt;
    logic                 ovf;

    modport master (
        input  sync_in, din_vld, acc_len, rd_done, ovf_clr,
        output bl_sync, bl_en, acc_first, acc_last, acc_bank,
               rd_req, rd_bank, int_cnt, ovf
    );

    modport slave (
        output sync_in, din_vld, acc_len, rd_done, ovf_clr,
        input  bl_sync, bl_en, acc_first, acc_last, acc_bank,
               rd_req, rd_bank, int_cnt, ovf
    );
endinterface

// File: rtl/xeng_wrap_cnt.sv
// Modulo counter 0..max_val with synchronous clear; wrap flags the enabled
// step that returns it to zero, so counters cascade by chaining wrap into en.
module xeng_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    assign wrap = en && (cnt == max_val);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/xeng_acc_sched.sv
// X-engine integration scheduler: beat counting, accumulator first/last flags,
// bank double-buffering and readout handoff with overrun detection.
module xeng_acc_sched
    import xeng_pkg::*;
#(
    parameter int N_ANTS    = 16,
    parameter int N_CHANS   = 128,
    parameter int ACC_LEN_W = 16
) (
    input logic               clk,
    input logic               rst,
    xeng_acc_sched_if.master  bus
);
    localparam int N_BLS = n_bls(N_ANTS);
    localparam int BL_W  = log2w(N_BLS);
    localparam int CH_W  = log2w(N_CHANS);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(N_BLS - 1);
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_CHANS - 1);

    state_t               state;
    logic [ACC_LEN_W-1:0] acc_len_q;
    logic [ACC_LEN_W-1:0] acc_len_new;
    logic [ACC_LEN_W-1:0] acc_max;
    logic [ACC_LEN_W-1:0] acc_cnt;
    logic [BL_W-1:0]      bl_cnt;
    logic [CH_W-1:0]      chan_cnt;
    logic                 step;
    logic                 bl_wrap;
    logic                 chan_wrap;
    logic                 acc_wrap;
    logic                 bnd_p0;
    logic                 rd_busy;
    logic                 unused_cnt;

    // A beat coinciding with sync_in belongs to the discarded partial integration.
    assign step        = (state == ST_RUN) && bus.din_vld && !bus.sync_in;
    assign acc_len_new = (bus.acc_len == '0) ? ACC_LEN_W'(1) : bus.acc_len;
    assign acc_max     = acc_len_q - ACC_LEN_W'(1);
    assign rd_busy     = bus.rd_req && !bus.rd_done;
    assign unused_cnt  = ^{bl_cnt, chan_cnt};

    xeng_wrap_cnt #(.W(BL_W)) u_bl_cnt (
        .clk(clk), .rst(rst), .en(step), .clr(bus.sync_in),
        .max_val(BL_MAX), .cnt(bl_cnt), .wrap(bl_wrap)
    );

    xeng_wrap_cnt #(.W(CH_W)) u_chan_cnt (
        .clk(clk), .rst(rst), .en(bl_wrap), .clr(bus.sync_in),
        .max_val(CH_MAX), .cnt(chan_cnt), .wrap(chan_wrap)
    );

    xeng_wrap_cnt #(.W(ACC_LEN_W)) u_acc_cnt (
        .clk(clk), .rst(rst), .en(chan_wrap), .clr(bus.sync_in),
        .max_val(acc_max), .cnt(acc_cnt), .wrap(acc_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc_len_q     <= ACC_LEN_W'(1);
            bnd_p0        <= 1'b0;
            bus.bl_sync   <= 1'b0;
            bus.bl_en     <= 1'b0;
            bus.acc_first <= 1'b0;
            bus.acc_last  <= 1'b0;
            bus.acc_bank  <= 1'b0;
            bus.rd_req    <= 1'b0;
            bus.rd_bank   <= 1'b0;
            bus.int_cnt   <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            if (bus.sync_in) begin
                state <= ST_RUN;
            end
            // Latch on the boundary beat itself so the very next beat already
            // sees the new integration length.
            if (bus.sync_in || acc_wrap) begin
                acc_len_q <= acc_len_new;
            end

            // p0: beat flags; the bank/handoff update follows one cycle later
            bnd_p0        <= acc_wrap;
            bus.bl_sync   <= bus.sync_in;
            bus.bl_en     <= step;
            bus.acc_first <= step && (acc_cnt == '0);
            bus.acc_last  <= step && (acc_cnt == acc_max);

            // A same-cycle rd_done frees the slot before the boundary is judged.
            if (bnd_p0 && !rd_busy) begin
                bus.rd_req   <= 1'b1;
                bus.rd_bank  <= bus.acc_bank;
                bus.acc_bank <= ~bus.acc_bank;
                bus.int_cnt  <= bus.int_cnt + ACC_LEN_W'(1);
            end else if (bus.rd_done) begin
                bus.rd_req <= 1'b0;
            end

            if (bnd_p0 && rd_busy) begin
                bus.ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                bus.ovf <= 1'b0;
            end
        end
    end
endmodule

// File: doc/xeng_acc_sched.md
Name: xeng_acc_sched

Overview:
Integration scheduler for the X-engine correlator core. It counts valid input beats and drives the enable and resync for the baseline order generator. It flags the first and last spectrum of each integration to the accumulators and double-buffers the accumulator banks. It also hands each completed bank to the readout engine with a req/done handshake and detects readout overruns.

Parameters:
N_ANTS, 16, antennas per X-engine; power of two, >=4
N_CHANS, 128, frequency channels per X-engine per spectrum; >=1
ACC_LEN_W, 16, width of the acc_len input and the integration counter
N_BLS (localparam), N_ANTS*(N_ANTS/2+1), baseline-order slots per channel (144 at default)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sync_in  in  1  frame sync pulse; starts or restarts scheduling
din_vld  in  1  one beat per baseline slot of corner-turned data
acc_len  in  ACC_LEN_W  spectra per integration; 0 is treated as 1
rd_done  in  1  readout engine finished draining rd_bank (1-cycle pulse)
ovf_clr  in  1  clears the sticky ovf flag
bl_sync  out  1  resync pulse to the baseline order generator
bl_en  out  1  step enable to the baseline order generator
acc_first  out  1  this beat is the first spectrum of an integration (accumulator loads, no add)
acc_last  out  1  this beat is the last spectrum of an integration
acc_bank  out  1  accumulator bank being written
rd_req  out  1  completed bank awaiting readout
rd_bank  out  1  bank to read; valid while rd_req=1
int_cnt  out  ACC_LEN_W  completed integrations handed to readout (wraps)
ovf  out  1  sticky: an integration completed while rd_req was still high

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- FSM:
  - IDLE: after rst. Moves to RUN on sync_in=1.
  - RUN: moves back to IDLE only on rst.
- Any sync_in (IDLE or RUN) does all of the following:
  - clears bl_cnt, chan_cnt and acc_cnt;
  - latches acc_len_q = max(acc_len,1);
  - pulses bl_sync for exactly 1 cycle on the next cycle.
- Any partial integration is discarded. acc_bank, rd_req, rd_bank, int_cnt and ovf are unaffected by sync_in.
- In IDLE, din_vld is ignored and bl_en stays 0.
- In RUN, each din_vld produces on the next cycle:
  - bl_en=1;
  - acc_first=(acc_cnt==0);
  - acc_last=(acc_cnt==acc_len_q-1);
  - acc_bank = current bank.
  - Latency is exactly 1 cycle. Without din_vld, bl_en, acc_first and acc_last are 0.
- Counter nesting, all advancing on din_vld in RUN:
  - bl_cnt runs 0..N_BLS-1 and wraps.
  - On bl_cnt wrap, chan_cnt advances 0..N_CHANS-1 and wraps.
  - On chan_cnt wrap, acc_cnt advances 0..acc_len_q-1 and wraps.
- Integration boundary is the din_vld beat with all three counters at their maximum. On the cycle after that beat:
  - If rd_req==0: rd_req<=1, rd_bank<=acc_bank, acc_bank<=~acc_bank, int_cnt<=int_cnt+1.
  - If rd_req==1 (overrun): ovf<=1. The bank does not toggle and int_cnt does not change. The next integration overwrites the same bank, which is safe because acc_first reloads it. rd_req and rd_bank hold.
  - In both cases acc_len_q re-latches from acc_len. acc_len changes take effect only here or at sync_in.
- rd_done while rd_req=1 clears rd_req on the next cycle. rd_done while rd_req=0 is ignored.
- rd_done on the same cycle as the boundary update is resolved on the current rd_req value, before the update:
  - the boundary is not an overrun;
  - on the next cycle rd_req=1 and rd_bank = the newly completed bank.
- sync_in on the same cycle as the boundary din_vld: sync_in wins; no handoff occurs.
- ovf: sticky. Cleared by ovf_clr or rst. A set event in the same cycle as ovf_clr leaves ovf=1.
- rst mid-integration: all counters, bank state, rd_req and outputs go to 0 on the next cycle; FSM returns to IDLE.
- Each counter's width is log2 of its range. int_cnt wraps at 2^ACC_LEN_W.

Decomposition:
- Shared package xeng_pkg: N_BLS derivation, log2 function, FSM state encoding (IDLE/RUN).
- One natural sub-module: xeng_wrap_cnt, a parameterised modulo counter with en, clr, load-max and a wrap flag output. It is instantiated three times in cascade (bl, chan, acc).
- FSM, bank/handshake logic and output registers stay in the top module.

Test Plan:
Common settings for all scenarios: N_ANTS=4 (N_BLS=12), N_CHANS=2, acc_len=3, so one integration = 72 din_vld.

1. rst, sync_in, 72 contiguous din_vld:
   - bl_sync pulses once;
   - acc_first=1 on beats 1-24, acc_last=1 on beats 49-72;
   - 1 cycle after beat 72: rd_req=1, rd_bank=0, acc_bank=1, int_cnt=1.
2. Same as 1, then 72 more beats with no rd_done:
   - ovf=1, acc_bank stays 1, int_cnt=1, rd_bank=0.
   - Then pulse ovf_clr: ovf=0.
3. rd_done pulsed on the exact cycle of the second boundary update:
   - no ovf;
   - next cycle rd_req=1, rd_bank=1, acc_bank=0, int_cnt=2.
4. sync_in after beat 40:
   - counters restart, bl_sync pulses, acc_first=1 for the next 24 beats;
   - no handoff until 72 further beats.
5. acc_len changed to 1 mid-integration:
   - current integration still completes at beat 72;
   - the next integration completes after 24 beats;
   - with acc_len=0, every beat has acc_first=acc_last=1.
6. Irregular din_vld (random gaps) and rst asserted at beat 30:
   - all outputs 0 next cycle;
   - din_vld ignored until sync_in;
   - bl_en count always equals din_vld count while in RUN.
